// File: rtl/stage_id_buf.sv
// stage_id_buf: buffered instruction-decode stage between IF and EX.
// Contains the rvcpu package, the decoder and gen_imm blocks, and the
// stage_id_buf top (an in-order FIFO of decoded entries).
// Optional feature macro: RVCPU_ID_BYPASS_EN (write-back bypass at push and
// write-back snooping of buffered operand data).

package rvcpu;
    localparam int Width = 32;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] opcode_t;
    typedef logic [4:0]  reg_t;
    typedef logic [3:0]  op_t;

    typedef enum logic [2:0] {
        UNIT_NONE = 3'd0,
        UNIT_ALU  = 3'd1,
        UNIT_BRU  = 3'd2,
        UNIT_LSU  = 3'd3,
        UNIT_SYS  = 3'd4
    } unit_e;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // ALU ops are {funct7[5], funct3}; the unused codes carry LUI/AUIPC.
    // Branch-unit ops are {0, funct3} for branches, plus JAL/JALR.
    // LSU ops are {is_store, funct3}. System ops are enumerated below.
    localparam op_t OP_LUI    = 4'b1001;
    localparam op_t OP_AUIPC  = 4'b1010;
    localparam op_t OP_JAL    = 4'b1000;
    localparam op_t OP_JALR   = 4'b1001;
    localparam op_t OP_ECALL  = 4'd0;
    localparam op_t OP_EBREAK = 4'd1;
    localparam op_t OP_WFI    = 4'd2;
    localparam op_t OP_FENCE  = 4'd3;

    typedef struct packed {
        pc_t              pc;
        reg_t             rd;
        logic             rs1_valid;
        logic             rs2_valid;
        logic             rd_valid;
        logic             vld_decode;
        unit_e            unit;
        op_t              op;
        logic             is_wfi;
        logic [Width-1:0] imm;
        logic [Width-1:0] rs1_data;
        logic [Width-1:0] rs2_data;
    } stage_id_t;
endpackage

// decoder: RV32I classification; every valid flag is forced low for an
// illegal encoding so downstream never sees a half-decoded instruction.
module decoder (
    input  rvcpu::opcode_t i_opcode,
    output logic           o_vld,
    output logic           o_rs1_valid,
    output logic           o_rs2_valid,
    output logic           o_rd_valid,
    output logic           o_is_wfi,
    output rvcpu::unit_e   o_unit,
    output rvcpu::op_t     o_op,
    output rvcpu::fmt_e    o_fmt
);
    import rvcpu::*;

    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_vld;
    logic       w_rs1;
    logic       w_rs2;
    logic       w_writes;

    assign w_f3 = i_opcode[14:12];
    assign w_f7 = i_opcode[31:25];

    // Major-opcode decode with funct3/funct7 legality checks
    always_comb begin
        w_vld    = 1'b0;
        w_rs1    = 1'b0;
        w_rs2    = 1'b0;
        w_writes = 1'b0;
        o_is_wfi = 1'b0;
        o_unit   = UNIT_NONE;
        o_op     = 4'd0;
        o_fmt    = FMT_NONE;
        case (i_opcode[6:0])
            7'b0110111: begin
                w_vld = 1'b1; w_writes = 1'b1; o_unit = UNIT_ALU; o_op = OP_LUI; o_fmt = FMT_U;
            end
            7'b0010111: begin
                w_vld = 1'b1; w_writes = 1'b1; o_unit = UNIT_ALU; o_op = OP_AUIPC; o_fmt = FMT_U;
            end
            7'b1101111: begin
                w_vld = 1'b1; w_writes = 1'b1; o_unit = UNIT_BRU; o_op = OP_JAL; o_fmt = FMT_J;
            end
            7'b1100111: begin
                w_vld = (w_f3 == 3'b000); w_rs1 = 1'b1; w_writes = 1'b1;
                o_unit = UNIT_BRU; o_op = OP_JALR; o_fmt = FMT_I;
            end
            7'b1100011: begin
                w_vld = (w_f3 != 3'b010) && (w_f3 != 3'b011); w_rs1 = 1'b1; w_rs2 = 1'b1;
                o_unit = UNIT_BRU; o_op = {1'b0, w_f3}; o_fmt = FMT_B;
            end
            7'b0000011: begin
                w_vld = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_rs1 = 1'b1; w_writes = 1'b1; o_unit = UNIT_LSU; o_op = {1'b0, w_f3}; o_fmt = FMT_I;
            end
            7'b0100011: begin
                w_vld = (w_f3[2] == 1'b0) && (w_f3 != 3'b011); w_rs1 = 1'b1; w_rs2 = 1'b1;
                o_unit = UNIT_LSU; o_op = {1'b1, w_f3}; o_fmt = FMT_S;
            end
            7'b0010011: begin
                w_rs1 = 1'b1; w_writes = 1'b1; o_unit = UNIT_ALU; o_fmt = FMT_I;
                o_op = {1'b0, w_f3};
                if (w_f3 == 3'b001) begin
                    w_vld = (w_f7 == 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_vld = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                    o_op  = {w_f7[5], w_f3};
                end else begin
                    w_vld = 1'b1;
                end
            end
            7'b0110011: begin
                w_vld = (w_f7 == 7'h00) ||
                        ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_rs1 = 1'b1; w_rs2 = 1'b1; w_writes = 1'b1;
                o_unit = UNIT_ALU; o_op = {w_f7[5], w_f3};
            end
            7'b0001111: begin
                w_vld = 1'b1; o_unit = UNIT_SYS; o_op = OP_FENCE;
            end
            7'b1110011: begin
                o_unit = UNIT_SYS;
                if (i_opcode == 32'h1050_0073) begin
                    w_vld = 1'b1; o_op = OP_WFI; o_is_wfi = 1'b1;
                end else if (i_opcode == 32'h0000_0073) begin
                    w_vld = 1'b1; o_op = OP_ECALL;
                end else if (i_opcode == 32'h0010_0073) begin
                    w_vld = 1'b1; o_op = OP_EBREAK;
                end
            end
            default: ;
        endcase
    end

    assign o_vld       = w_vld;
    assign o_rs1_valid = w_vld && w_rs1;
    assign o_rs2_valid = w_vld && w_rs2;
    assign o_rd_valid  = w_vld && w_writes && (i_opcode[11:7] != 5'd0);
endmodule

// gen_imm: reassembles the format's scattered immediate bits, sign-extended.
module gen_imm #(
    parameter int Width = rvcpu::Width
) (
    input  rvcpu::opcode_t   i_opcode,
    input  rvcpu::fmt_e      i_fmt,
    output logic [Width-1:0] o_imm
);
    import rvcpu::*;

    logic [31:0] w_imm32;
    logic        w_unused_major;

    // The major opcode bits never carry immediate data
    assign w_unused_major = ^i_opcode[6:0];

    // Immediate reassembly per instruction format
    always_comb begin
        w_imm32 = 32'd0;
        case (i_fmt)
            FMT_I: w_imm32 = {{20{i_opcode[31]}}, i_opcode[31:20]};
            FMT_S: w_imm32 = {{20{i_opcode[31]}}, i_opcode[31:25], i_opcode[11:7]};
            FMT_B: w_imm32 = {{19{i_opcode[31]}}, i_opcode[31], i_opcode[7],
                              i_opcode[30:25], i_opcode[11:8], 1'b0};
            FMT_U: w_imm32 = {i_opcode[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{i_opcode[31]}}, i_opcode[31], i_opcode[19:12],
                              i_opcode[20], i_opcode[30:21], 1'b0};
            default: ;
        endcase
    end

    assign o_imm = Width'($signed(w_imm32));
endmodule

// stage_id_buf: decode + in-order FIFO towards EX.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, in_ready depends only on registered
// occupancy, and flush cancels both the push and the pop of that cycle.
module stage_id_buf #(
    parameter int Width = rvcpu::Width,
    parameter int Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  rvcpu::pc_t                   in_pc,
    input  rvcpu::opcode_t               in_opcode,
    output rvcpu::reg_t                  rs1,
    output rvcpu::reg_t                  rs2,
    input  logic [Width-1:0]             rs1_data,
    input  logic [Width-1:0]             rs2_data,
    input  logic                         wb_valid,
    input  rvcpu::reg_t                  wb_rd,
    input  logic [Width-1:0]             wb_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output rvcpu::stage_id_t             out,
    output logic [$clog2(Depth+1)-1:0]   count
);
    import rvcpu::*;

    // A single-entry buffer still gets a 1-bit pointer, held at zero
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] FULL    = CW'(Depth);
    localparam logic [PW-1:0] PTR_ONE = (Depth > 1) ? PW'(1) : PW'(0);

    stage_id_t        r_mem [Depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_vld;
    logic             w_rs1_valid;
    logic             w_rs2_valid;
    logic             w_rd_valid;
    logic             w_is_wfi;
    unit_e            w_unit;
    op_t              w_op;
    fmt_e             w_fmt;
    logic [Width-1:0] w_imm;
    logic [Width-1:0] w_op1;
    logic [Width-1:0] w_op2;
    stage_id_t        w_entry;

    assign rs1 = in_opcode[19:15];
    assign rs2 = in_opcode[24:20];

    decoder u_decoder (
        .i_opcode    (in_opcode),
        .o_vld       (w_vld),
        .o_rs1_valid (w_rs1_valid),
        .o_rs2_valid (w_rs2_valid),
        .o_rd_valid  (w_rd_valid),
        .o_is_wfi    (w_is_wfi),
        .o_unit      (w_unit),
        .o_op        (w_op),
        .o_fmt       (w_fmt)
    );

    gen_imm #(.Width(Width)) u_gen_imm (
        .i_opcode (in_opcode),
        .i_fmt    (w_fmt),
        .o_imm    (w_imm)
    );

`ifdef RVCPU_ID_BYPASS_EN
    logic        w_wb_hit;
    reg_t        r_rs1_idx [Depth];
    reg_t        r_rs2_idx [Depth];

    // x0 is hard-wired, so a write-back to it must never forward
    assign w_wb_hit = wb_valid && (wb_rd != 5'd0);
    assign w_op1    = (w_wb_hit && (wb_rd == rs1)) ? wb_data : rs1_data;
    assign w_op2    = (w_wb_hit && (wb_rd == rs2)) ? wb_data : rs2_data;

    // Source indices per slot, kept alongside the entry for snooping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                r_rs1_idx[i] <= '0;
                r_rs2_idx[i] <= '0;
            end
        end else if (w_push) begin
            r_rs1_idx[r_wr_ptr] <= rs1;
            r_rs2_idx[r_wr_ptr] <= rs2;
        end
    end
`else
    logic w_unused_wb;

    assign w_unused_wb = ^{wb_valid, wb_rd, wb_data};
    assign w_op1       = rs1_data;
    assign w_op2       = rs2_data;
`endif

    // Assemble the entry that a push would store this cycle
    always_comb begin
        w_entry            = '0;
        w_entry.pc         = in_pc;
        w_entry.rd         = in_opcode[11:7];
        w_entry.rs1_valid  = w_rs1_valid;
        w_entry.rs2_valid  = w_rs2_valid;
        w_entry.rd_valid   = w_rd_valid;
        w_entry.vld_decode = w_vld;
        w_entry.unit       = w_unit;
        w_entry.op         = w_op;
        w_entry.is_wfi     = w_is_wfi;
        w_entry.imm        = w_imm;
        w_entry.rs1_data   = w_op1;
        w_entry.rs2_data   = w_op2;
    end

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign out       = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; the push slot is never occupied, so it cannot collide
    // with a snoop update of a live entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
`ifdef RVCPU_ID_BYPASS_EN
            // Stale or empty slots may also be refreshed; their data is dead
            for (int i = 0; i < Depth; i++) begin
                if (w_wb_hit && r_mem[i].rs1_valid && (r_rs1_idx[i] == wb_rd))
                    r_mem[i].rs1_data <= wb_data;
                if (w_wb_hit && r_mem[i].rs2_valid && (r_rs2_idx[i] == wb_rd))
                    r_mem[i].rs2_data <= wb_data;
            end
`endif
            if (w_push) r_mem[r_wr_ptr] <= w_entry;
        end
    end
endmodule
